// File: rtl/cci_mpf_prim_arb_fifo1.sv
// Round-robin arbiter in front of a single-entry output FIFO.
// Each requester owns one input slot; one grant per cycle feeds the output entry.
module cci_mpf_prim_arb_fifo1 #(
    parameter int N_REQ       = 4,
    parameter int N_DATA_BITS = 32
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [N_REQ*N_DATA_BITS-1:0]   enq_data,
    input  logic [N_REQ-1:0]               enq_en,
    output logic [N_REQ-1:0]               notFull,
    output logic [N_DATA_BITS-1:0]         first,
    output logic [$clog2(N_REQ)-1:0]       first_src,
    input  logic                           deq_en,
    output logic                           notEmpty
);

    localparam int              SW     = $clog2(N_REQ);
    localparam logic [SW:0]     NREQ_X = (SW+1)'(N_REQ);
    localparam logic [SW-1:0]   LAST   = SW'(N_REQ - 1);

    logic [N_REQ-1:0]       slot_valid_q, slot_valid_d;
    logic [N_DATA_BITS-1:0] slot_data_q [N_REQ];
    logic [N_DATA_BITS-1:0] slot_data_d [N_REQ];
    logic                   out_valid_q, out_valid_d;
    logic [N_DATA_BITS-1:0] out_data_q, out_data_d;
    logic [SW-1:0]          out_src_q, out_src_d;
    logic [SW-1:0]          rr_ptr_q, rr_ptr_d;

    logic                   out_free;
    logic                   grant;
    logic [SW-1:0]          grant_idx;
    logic [SW:0]            idx;
    logic [N_REQ-1:0]       enq_ok;

    assign out_free  = !out_valid_q || deq_en;
    assign enq_ok    = enq_en & ~slot_valid_q;

    assign notFull   = ~slot_valid_q;
    assign notEmpty  = out_valid_q;
    assign first     = out_data_q;
    assign first_src = out_src_q;

    // Round-robin search: first valid slot at or after rr_ptr, wrapping at N_REQ.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (SW+1)'(k);
            if (idx >= NREQ_X) begin
                idx = idx - NREQ_X;
            end
            if (out_free && !grant && slot_valid_q[idx[SW-1:0]]) begin
                grant     = 1'b1;
                grant_idx = idx[SW-1:0];
            end
        end
    end

    // Next state: slot loads, grant transfer into the output entry, dequeue.
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_data_d  = slot_data_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        rr_ptr_d     = rr_ptr_q;

        for (int i = 0; i < N_REQ; i++) begin
            if (enq_ok[i]) begin
                slot_valid_d[i] = 1'b1;
                slot_data_d[i]  = enq_data[i*N_DATA_BITS +: N_DATA_BITS];
            end
        end

        if (grant) begin
            slot_valid_d[grant_idx] = 1'b0;
            out_valid_d = 1'b1;
            out_data_d  = slot_data_q[grant_idx];
            out_src_d   = grant_idx;
            rr_ptr_d    = (grant_idx == LAST) ? '0 : grant_idx + SW'(1);
        end else if (deq_en) begin
            out_valid_d = 1'b0;
        end
    end

    // Control state, asynchronously cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid_q <= '0;
            out_valid_q  <= 1'b0;
            out_src_q    <= '0;
            rr_ptr_q     <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            out_valid_q  <= out_valid_d;
            out_src_q    <= out_src_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    // Payload registers carry no reset; they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        slot_data_q <= slot_data_d;
        out_data_q  <= out_data_d;
    end

`ifndef SYNTHESIS
    // Protocol checks: enqueue into a full slot or dequeue from an empty output.
    always @(posedge clk) begin
        if (reset_n) begin
            assert ((enq_en & slot_valid_q) == '0)
                else $fatal(1, "enq_en asserted while notFull is low");
            assert (!(deq_en && !out_valid_q))
                else $fatal(1, "deq_en asserted while notEmpty is low");
        end
    end
`endif

endmodule

// File: tb/tb_cci_mpf_prim_arb_fifo1.sv
// Bench for cci_mpf_prim_arb_fifo1: directed scenarios plus random traffic
// checked each cycle against a queue-based reference model.
module tb_cci_mpf_prim_arb_fifo1;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk;
    logic           reset_n;
    logic [N*W-1:0] enq_data;
    logic [N-1:0]   enq_en;
    logic [N-1:0]   notFull;
    logic [W-1:0]   first;
    logic [1:0]     first_src;
    logic           deq_en;
    logic           notEmpty;

    cci_mpf_prim_arb_fifo1 #(.N_REQ(N), .N_DATA_BITS(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enq_data  (enq_data),
        .enq_en    (enq_en),
        .notFull   (notFull),
        .first     (first),
        .first_src (first_src),
        .deq_en    (deq_en),
        .notEmpty  (notEmpty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Reference model: one-deep slot per requester, one output entry,
    // plus per-requester payload queues for ordering.
    bit           m_sv [N];
    logic [W-1:0] m_sd [N];
    bit           m_ov;
    logic [W-1:0] m_od;
    int           m_os;
    int           m_ptr;
    logic [W-1:0] sb [N][$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_nf();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = !m_sv[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sv[i] = 0;
            sb[i].delete();
        end
        m_ov  = 0;
        m_os  = 0;
        m_ptr = 0;
    endtask

    task automatic model_step(input logic [N-1:0] en,
                              input logic [N*W-1:0] d, input logic dq);
        int g = -1;
        if (!m_ov || dq) begin
            for (int k = 0; k < N; k++) begin
                int j = (m_ptr + k) % N;
                if (g < 0 && m_sv[j]) g = j;
            end
        end
        if (g >= 0) begin
            m_od    = m_sd[g];
            m_os    = g;
            m_ov    = 1;
            m_sv[g] = 0;
            m_ptr   = (g + 1) % N;
        end else if (dq) begin
            m_ov = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (en[i]) begin
                m_sv[i] = 1;
                m_sd[i] = d[i*W +: W];
                sb[i].push_back(d[i*W +: W]);
            end
        end
    endtask

    // One clock: drive legal inputs, advance model at the edge, return edge+1.
    task automatic cycle(input logic [N-1:0] en, input logic [N*W-1:0] d,
                         input logic dq);
        logic [N-1:0] en_e;
        logic         dq_e;
        logic [W-1:0] exp;
        en_e = en & m_nf();
        dq_e = dq & m_ov;
        enq_en   = en_e;
        enq_data = d;
        deq_en   = dq_e;
        if (dq_e) begin
            exp = sb[m_os].pop_front();
            chk("deq_order", first, exp);
        end
        @(posedge clk);
        model_step(en_e, d, dq_e);
        #1;
        enq_en = '0;
        deq_en = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enq_en  = '0;
        deq_en  = 1'b0;
        model_reset();
        #1;
        chk("rst_notFull", notFull, 4'b1111);
        chk("rst_notEmpty", notEmpty, 1'b0);
        chk("rst_first_src", first_src, 2'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("notFull", notFull, m_nf());
            chk("notEmpty", notEmpty, m_ov);
            if (m_ov) begin
                chk("first", first, m_od);
                chk("first_src", first_src, m_os);
            end
        end
    end

    initial begin
        logic [N*W-1:0] d;
        logic [N-1:0]   en;
        int             exp_src;
        reset_n  = 1'b0;
        enq_en   = '0;
        deq_en   = 1'b0;
        enq_data = '0;
        #2;
        do_reset();
        chk_en = 1;

        // Single requester latency.
        d = '0;
        d[2*W +: W] = 32'hA5A5_0002;
        cycle(4'b0100, d, 1'b0);
        chk("s_nf_t1", notFull, 4'b1011);
        chk("s_ne_t1", notEmpty, 1'b0);
        cycle('0, '0, 1'b0);
        chk("s_ne_t2", notEmpty, 1'b1);
        chk("s_first_t2", first, 32'hA5A5_0002);
        chk("s_src_t2", first_src, 2'd2);
        chk("s_nf_t2", notFull, 4'b1111);
        cycle('0, '0, 1'b1);
        chk("s_ne_t3", notEmpty, 1'b0);

        // All four contend in the same cycle.
        do_reset();
        d = {32'h13, 32'h12, 32'h11, 32'h10};
        cycle(4'b1111, d, 1'b0);
        for (int k = 0; k < N; k++) begin
            cycle('0, '0, 1'b1);
            chk("c_src", first_src, k);
            chk("c_first", first, 32'h10 + k);
        end
        cycle('0, '0, 1'b1);
        chk("c_empty", notEmpty, 1'b0);

        // Fairness between requesters 0 and 3.
        do_reset();
        exp_src = 0;
        for (int k = 0; k < 10; k++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            cycle(4'b1001, d, 1'b1);
            if (k >= 1) begin
                chk("f_ne", notEmpty, 1'b1);
                chk("f_src", first_src, exp_src);
                exp_src = (exp_src == 0) ? 3 : 0;
            end
        end
        for (int k = 0; k < 3; k++) cycle('0, '0, 1'b1);

        // Backpressure holds the output and the waiting slots.
        do_reset();
        d = {32'h0, 32'h22, 32'h21, 32'h20};
        cycle(4'b0111, d, 1'b0);
        cycle('0, '0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle('0, '0, 1'b0);
            chk("b_first", first, 32'h20);
            chk("b_nf", notFull, 4'b1001);
        end
        cycle('0, '0, 1'b1);
        chk("b_src1", first_src, 2'd1);
        cycle('0, '0, 1'b1);
        chk("b_src2", first_src, 2'd2);
        cycle('0, '0, 1'b1);

        // Reset with everything occupied.
        do_reset();
        d = {32'h33, 32'h32, 32'h31, 32'h30};
        cycle(4'b1111, d, 1'b0);
        cycle('0, '0, 1'b0);
        cycle(4'b0001, d, 1'b0);
        chk("r_full", notFull, 4'b0000);
        chk("r_ne", notEmpty, 1'b1);
        do_reset();
        d = {32'h43, 32'h42, 32'h41, 32'h40};
        cycle(4'b1010, d, 1'b0);
        cycle('0, '0, 1'b0);
        chk("r_src1", first_src, 2'd1);
        chk("r_first1", first, 32'h41);
        cycle('0, '0, 1'b1);
        chk("r_src3", first_src, 2'd3);
        chk("r_first3", first, 32'h43);
        cycle('0, '0, 1'b1);

        // Random traffic with one mid-run reset.
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) do_reset();
            en = N'($urandom);
            d  = {$urandom, $urandom, $urandom, $urandom};
            cycle(en, d, ($urandom % 4) != 0);
        end
        for (int k = 0; k < 8; k++) cycle('0, '0, 1'b1);
        chk("drain_empty", notEmpty, 1'b0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
